// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - datapath request/response and data-memory port bundle
// master = datapath + memory environment, slave = the load/store unit
interface mem_access_unit_if #(
   parameter int DATA_W     = 32,
   parameter int DM_ADDRESS = 9
);
   logic                  req_valid;
   logic                  req_we;
   logic [2:0]            req_funct3;
   logic [DATA_W-1:0]     req_addr;
   logic [DATA_W-1:0]     req_wdata;
   logic                  req_ready;
   logic                  stall;
   logic                  resp_valid;
   logic                  resp_err;
   logic [DATA_W-1:0]     resp_rdata;
   logic                  mem_req;
   logic                  mem_we;
   logic [DM_ADDRESS-1:0] mem_addr;
   logic [3:0]            mem_be;
   logic [31:0]           mem_wdata;
   logic                  mem_ack;
   logic [31:0]           mem_rdata;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
      input  req_ready, stall, resp_valid, resp_err, resp_rdata,
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
      output req_ready, stall, resp_valid, resp_err, resp_rdata,
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata
   );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - RV32I load/store unit driving a word-wide data memory port
// One request in flight; misaligned/illegal requests and memory timeouts return resp_err.
module mem_access_unit #(
   parameter int DATA_W     = 32,
   parameter int DM_ADDRESS = 9,
   parameter int TIMEOUT    = 16
) (
   input  logic             clk,
   input  logic             reset,
   mem_access_unit_if.slave bus
);
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;
   state_t state, state_nxt;

   logic                  r_we;
   logic [2:0]            r_funct3;
   logic [1:0]            r_lane;
   logic [DM_ADDRESS-1:0] r_addr;
   logic [3:0]            r_be;
   logic [31:0]           r_wdata;
   logic [CNT_W-1:0]      cnt;
   logic                  r_err;
   logic [DATA_W-1:0]     r_rdata;

   logic              req_legal, req_aligned, req_ok, timeout_hit;
   logic [3:0]        be_nxt;
   logic [31:0]       wdata_nxt;
   logic [7:0]        ld_byte;
   logic [15:0]       ld_half;
   logic [DATA_W-1:0] load_ext;
   logic              ready_c, mem_req_c, resp_valid_c;
   logic              unused_addr_hi;

   assign unused_addr_hi = ^bus.req_addr[DATA_W-1:DM_ADDRESS];

   always_comb begin
      req_legal   = 1'b0;
      req_aligned = 1'b1;
      case (bus.req_funct3)
         3'b000, 3'b001, 3'b010: req_legal = 1'b1;
         3'b100, 3'b101:         req_legal = !bus.req_we;
         default:                req_legal = 1'b0;
      endcase
      case (bus.req_funct3[1:0])
         2'b01:   req_aligned = !bus.req_addr[0];
         2'b10:   req_aligned = (bus.req_addr[1:0] == 2'b00);
         default: req_aligned = 1'b1;
      endcase
      req_ok = req_legal && req_aligned;
   end

   // Store data is replicated across lanes so the memory only has to honour byte enables.
   always_comb begin
      be_nxt    = 4'b1111;
      wdata_nxt = 32'd0;
      if (bus.req_we) begin
         case (bus.req_funct3[1:0])
            2'b00: begin
               be_nxt    = 4'b0001 << bus.req_addr[1:0];
               wdata_nxt = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
               be_nxt    = 4'b0011 << {bus.req_addr[1], 1'b0};
               wdata_nxt = {2{bus.req_wdata[15:0]}};
            end
            default: wdata_nxt = bus.req_wdata[31:0];
         endcase
      end
   end

   always_comb begin
      ld_byte = bus.mem_rdata[8*r_lane +: 8];
      ld_half = bus.mem_rdata[16*r_lane[1] +: 16];
      case (r_funct3)
         3'b000:  load_ext = DATA_W'($signed(ld_byte));
         3'b001:  load_ext = DATA_W'($signed(ld_half));
         3'b100:  load_ext = DATA_W'(ld_byte);
         3'b101:  load_ext = DATA_W'(ld_half);
         default: load_ext = DATA_W'(bus.mem_rdata);
      endcase
   end

   assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.req_valid) state_nxt = req_ok ? ACCESS : RESP;
         ACCESS:  if (bus.mem_ack || timeout_hit) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ready_c      = 1'b0;
      mem_req_c    = 1'b0;
      resp_valid_c = 1'b0;
      case (state)
         IDLE:    ready_c      = reset;
         ACCESS:  mem_req_c    = 1'b1;
         RESP:    resp_valid_c = 1'b1;
         default: ;
      endcase
   end

   // Request fields are latched at accept; req_* changes afterwards are ignored.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_we     <= 1'b0;
         r_funct3 <= 3'd0;
         r_lane   <= 2'd0;
         r_addr   <= '0;
         r_be     <= 4'd0;
         r_wdata  <= 32'd0;
         cnt      <= '0;
         r_err    <= 1'b0;
         r_rdata  <= '0;
      end else begin
         case (state)
            IDLE: if (bus.req_valid) begin
               if (!req_ok) begin
                  r_err   <= 1'b1;
                  r_rdata <= '0;
               end else begin
                  r_we     <= bus.req_we;
                  r_funct3 <= bus.req_funct3;
                  r_lane   <= bus.req_addr[1:0];
                  r_addr   <= {bus.req_addr[DM_ADDRESS-1:2], 2'b00};
                  r_be     <= be_nxt;
                  r_wdata  <= wdata_nxt;
                  cnt      <= '0;
               end
            end
            ACCESS: begin
               if (bus.mem_ack) begin
                  r_err   <= 1'b0;
                  r_rdata <= r_we ? '0 : load_ext;
               end else if (timeout_hit) begin
                  r_err   <= 1'b1;
                  r_rdata <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.req_ready  = ready_c;
   assign bus.stall      = bus.req_valid & ~resp_valid_c;
   assign bus.resp_valid = resp_valid_c;
   assign bus.resp_err   = r_err;
   assign bus.resp_rdata = r_rdata;
   assign bus.mem_req    = mem_req_c;
   assign bus.mem_we     = r_we;
   assign bus.mem_addr   = r_addr;
   assign bus.mem_be     = r_be;
   assign bus.mem_wdata  = r_wdata;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
// Byte-array reference model; the bench also acts as the data memory.
module tb_mem_access_unit;
   localparam int DATA_W = 32;
   localparam int DM     = 9;
   localparam int TO     = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_access_unit_if #(.DATA_W(DATA_W), .DM_ADDRESS(DM)) bus();
   mem_access_unit #(.DATA_W(DATA_W), .DM_ADDRESS(DM), .TIMEOUT(TO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [7:0]    ref_bytes [512];
   logic [31:0]   mem_words [128];
   logic          cap_valid, cap_we;
   logic [DM-1:0] cap_addr;
   logic [3:0]    cap_be;
   logic [31:0]   cap_wdata;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_word(input int idx, input logic [31:0] v);
      mem_words[idx] = v;
      for (int i = 0; i < 4; i++) ref_bytes[idx*4+i] = v[8*i +: 8];
   endtask

   function automatic int acc_size(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         2'b10:   return 4;
         default: return 0;
      endcase
   endfunction

   function automatic logic ref_ok(input logic we, input logic [2:0] f3, input logic [31:0] addr);
      int sz = acc_size(f3);
      if (sz == 0) return 1'b0;
      if (f3[2] && (we || sz == 4)) return 1'b0;
      return (int'(addr[8:0]) % sz) == 0;
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
      int sz = acc_size(f3);
      int off = int'(addr[8:0]);
      logic [31:0] v = 32'd0;
      for (int i = 0; i < sz; i++) v = v | (32'(ref_bytes[off+i]) << (8*i));
      if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
      return v;
   endfunction

   task automatic ref_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
      int sz = acc_size(f3);
      int off = int'(addr[8:0]);
      for (int i = 0; i < sz; i++) ref_bytes[off+i] = wd[8*i +: 8];
   endtask

   // Drives one request, plays the memory (ack on the ack_at-th request cycle) and
   // returns the response plus latency in cycles after accept.
   task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input int ack_at,
                      output logic [31:0] rdata, output logic err, output int lat, output int reqcyc);
      logic got = 1'b0;
      int   idx;
      @(negedge clk);
      check("req_ready_idle", bus.req_ready, 1);
      bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
      bus.req_addr = addr; bus.req_wdata = wd;
      @(posedge clk);
      lat = 0; reqcyc = 0; cap_valid = 1'b0; rdata = '0; err = 1'b0;
      for (int n = 0; n < 40 && !got; n++) begin
         @(negedge clk);
         lat++;
         bus.req_addr = $urandom; bus.req_wdata = $urandom;
         bus.req_funct3 = 3'($urandom); bus.req_we = 1'($urandom);
         bus.mem_ack = 1'b0; bus.mem_rdata = $urandom;
         if (bus.resp_valid) begin
            got = 1'b1;
            rdata = bus.resp_rdata; err = bus.resp_err;
            check("stall_at_resp", bus.stall, 0);
            check("ready_in_resp", bus.req_ready, 0);
         end else begin
            check("stall_busy", bus.stall, 1);
            if (bus.mem_req) begin
               reqcyc++;
               if (!cap_valid) begin
                  cap_valid = 1'b1; cap_we = bus.mem_we; cap_addr = bus.mem_addr;
                  cap_be = bus.mem_be; cap_wdata = bus.mem_wdata;
               end
               if (reqcyc == ack_at) begin
                  idx = int'(bus.mem_addr) >> 2;
                  bus.mem_ack = 1'b1;
                  bus.mem_rdata = mem_words[idx];
                  if (bus.mem_we)
                     for (int i = 0; i < 4; i++)
                        if (bus.mem_be[i]) mem_words[idx][8*i +: 8] = bus.mem_wdata[8*i +: 8];
               end
            end
         end
      end
      if (!got) check("resp_seen", 0, 1);
      bus.req_valid = 1'b0;
      bus.mem_ack = 1'b0;
   endtask

   task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input int ack_at, output logic [31:0] rdata);
      logic err;
      int   lat, reqcyc;
      logic ok = ref_ok(we, f3, addr);
      logic [31:0] exp_rd = 32'd0;
      if (ok && ack_at <= TO && !we) exp_rd = ref_load(f3, addr);
      run(we, f3, addr, wd, ack_at, rdata, err, lat, reqcyc);
      if (!ok) begin
         check("err_illegal", err, 1);
         check("lat_illegal", lat, 1);
         check("reqcyc_illegal", reqcyc, 0);
      end else if (ack_at > TO) begin
         check("err_timeout", err, 1);
         check("lat_timeout", lat, TO + 1);
         check("reqcyc_timeout", reqcyc, TO);
      end else begin
         check("err_ok", err, 0);
         check("lat_ok", lat, ack_at + 1);
         check("reqcyc_ok", reqcyc, ack_at);
         if (we) ref_store(f3, addr, wd);
      end
      check("rdata", rdata, exp_rd);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd, a, w;
      logic [2:0]  f3;
      logic        we;
      reset = 1'b0;
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
      bus.req_addr = '0; bus.req_wdata = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
      for (int i = 0; i < 128; i++) set_word(i, $urandom);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", bus.req_ready, 0);
      check("rst_mem_req", bus.mem_req, 0);
      check("rst_resp_valid", bus.resp_valid, 0);
      check("rst_resp_err", bus.resp_err, 0);
      check("rst_resp_rdata", bus.resp_rdata, 0);
      check("rst_mem_be", bus.mem_be, 0);
      reset = 1'b1;

      set_word(4, 32'hDEAD_BEEF);
      xact(1'b0, 3'b010, 32'h10, 32'h0, 1, rd);
      check("lw_be", cap_be, 4'b1111);
      check("lw_we", cap_we, 0);
      check("lw_addr", cap_addr, 9'h010);

      set_word(4, 32'h80FF_1234);
      xact(1'b0, 3'b000, 32'h13, 32'h0, 1, rd);
      check("lb_val", rd, 32'hFFFF_FF80);
      xact(1'b0, 3'b100, 32'h13, 32'h0, 2, rd);
      check("lbu_val", rd, 32'h0000_0080);
      xact(1'b0, 3'b101, 32'h12, 32'h0, 3, rd);
      check("lhu_val", rd, 32'h0000_80FF);

      xact(1'b1, 3'b001, 32'h06, 32'h1234_ABCD, 1, rd);
      check("sh_we", cap_we, 1);
      check("sh_addr", cap_addr, 9'h004);
      check("sh_be", cap_be, 4'b1100);
      check("sh_wdata", cap_wdata, 32'hABCD_ABCD);
      xact(1'b1, 3'b000, 32'h01, 32'h0000_0077, 1, rd);
      check("sb_be", cap_be, 4'b0010);
      check("sb_wdata", cap_wdata, 32'h7777_7777);

      xact(1'b0, 3'b010, 32'h02, 32'h0, 1, rd);
      xact(1'b0, 3'b011, 32'h00, 32'h0, 1, rd);

      xact(1'b0, 3'b010, 32'h10, 32'h0, TO + 1, rd);
      xact(1'b0, 3'b010, 32'h10, 32'h0, TO, rd);
      check("ack_last_cycle", rd, 32'h80FF_1234);

      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h10;
      @(posedge clk);
      @(negedge clk);
      check("rst_mid_mem_req_before", bus.mem_req, 1);
      reset = 1'b0;
      bus.req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("rst_mid_mem_req_after", bus.mem_req, 0);
      check("rst_mid_ready_low", bus.req_ready, 0);
      reset = 1'b1;
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1111_2222;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_mid_ready_after", bus.req_ready, 1);
         check("rst_mid_no_resp", bus.resp_valid, 0);
      end
      bus.mem_ack = 1'b0;

      for (int t = 0; t < 80; t++) begin
         we = 1'($urandom);
         f3 = 3'($urandom);
         if ($urandom_range(0, 3) != 0) f3 = we ? 3'($urandom_range(0, 2)) : (($urandom_range(0, 1) != 0) ? 3'b010 : 3'($urandom_range(0, 5)));
         a = $urandom;
         if ($urandom_range(0, 1) != 0) a[1:0] = 2'b00;
         w = $urandom;
         xact(we, f3, a, w, int'($urandom_range(1, TO + 1)), rd);
      end

      for (int i = 0; i < 128; i++)
         check("mem_image", mem_words[i], {ref_bytes[4*i+3], ref_bytes[4*i+2], ref_bytes[4*i+1], ref_bytes[4*i]});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
